// File: rtl/fwd_pipe.sv
// Operand forwarding and load-use interlock for an in-order pipeline.
// A short table tracks producers in the stages after decode, from E to W.
// Each decode read port takes its operand from the youngest matching
// producer. It stalls decode while that producer's result is still too far
// away for the cycle in which the operand is consumed.
module fwd_pipe #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NRP   = 2,
    parameter int DEPTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_waddr,
    input  logic [1:0]          issue_tnew,
    input  logic                flush,
    input  logic [NRP*AW-1:0]   raddr,
    input  logic [NRP*2-1:0]    tuse,
    input  logic [NRP*DW-1:0]   rf_rdata,
    input  logic [DEPTH*DW-1:0] stage_data,
    output logic [NRP*DW-1:0]   fwd_data,
    output logic [NRP*3-1:0]    fwd_sel,
    output logic                stall,
    output logic [31:0]         stall_cnt
);

    logic [DEPTH-1:0] ent_valid;
    logic [AW-1:0]    ent_waddr [DEPTH];
    logic [1:0]       ent_tnew  [DEPTH];

    logic             load_e;
    logic             hit;
    int               hit_k;
    logic [1:0]       hit_tnew;

    // A producer enters E only if it really writes a non-zero register
    // and decode is neither frozen nor killed this cycle.
    assign load_e = issue_valid & issue_wen & (issue_waddr != '0) & ~stall & ~flush;

    // Advance the producer table one stage per cycle, counting down tnew.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_waddr[k] <= '0;
                ent_tnew[k]  <= '0;
            end
        end else begin
            ent_valid[0] <= load_e;
            ent_waddr[0] <= issue_waddr;
            ent_tnew[0]  <= issue_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_waddr[k] <= ent_waddr[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == 2'd0) ? 2'd0 : ent_tnew[k-1] - 2'd1;
            end
        end
    end

    // Saturating count of cycles spent stalled. Reset wins over a pending stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Per-port forwarding select and interlock. The stage scan runs from
    // oldest to youngest, so the youngest match is the last one written.
    // A not-yet-ready youngest match hides any older ready copy.
    always_comb begin
        fwd_data = rf_rdata;
        fwd_sel  = '0;
        stall    = 1'b0;
        hit      = 1'b0;
        hit_k    = 0;
        hit_tnew = 2'd0;
        for (int p = 0; p < NRP; p++) begin
            hit      = 1'b0;
            hit_k    = 0;
            hit_tnew = 2'd0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_valid[k] && (raddr[p*AW +: AW] != '0) &&
                    (ent_waddr[k] == raddr[p*AW +: AW])) begin
                    hit      = 1'b1;
                    hit_k    = k;
                    hit_tnew = ent_tnew[k];
                end
            end
            if (hit) begin
                if (hit_tnew == 2'd0) begin
                    fwd_sel[p*3 +: 3]   = 3'(hit_k + 1);
                    fwd_data[p*DW +: DW] = stage_data[hit_k*DW +: DW];
                end
                if (hit_tnew > tuse[p*2 +: 2]) begin
                    stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed bench for fwd_pipe at its default parameters.
// Inputs change 1 time unit after each rising edge. Checks happen 1 time
// unit after that, well before the next edge.
module tb_fwd_pipe;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int DEPTH = 3;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0001;
    localparam logic [31:0] SD_E = 32'h1111_1111;
    localparam logic [31:0] SD_M = 32'h2222_2222;
    localparam logic [31:0] SD_W = 32'h3333_3333;

    logic                clk = 1'b0;
    logic                reset;
    logic                issue_valid;
    logic                issue_wen;
    logic [AW-1:0]       issue_waddr;
    logic [1:0]          issue_tnew;
    logic                flush;
    logic [NRP*AW-1:0]   raddr;
    logic [NRP*2-1:0]    tuse;
    logic [NRP*DW-1:0]   rf_rdata;
    logic [DEPTH*DW-1:0] stage_data;
    logic [NRP*DW-1:0]   fwd_data;
    logic [NRP*3-1:0]    fwd_sel;
    logic                stall;
    logic [31:0]         stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_pipe #(.DW(DW), .AW(AW), .NRP(NRP), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_wen  (issue_wen),
        .issue_waddr(issue_waddr),
        .issue_tnew (issue_tnew),
        .flush      (flush),
        .raddr      (raddr),
        .tuse       (tuse),
        .rf_rdata   (rf_rdata),
        .stage_data (stage_data),
        .fwd_data   (fwd_data),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_waddr = '0;
        issue_tnew  = 2'd0;
        flush       = 1'b0;
        raddr       = '0;
        tuse        = '0;
    endtask

    task automatic issue(input logic [AW-1:0] wa, input logic [1:0] tn);
        issue_valid = 1'b1;
        issue_wen   = 1'b1;
        issue_waddr = wa;
        issue_tnew  = tn;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic port(input int p, input logic [AW-1:0] ra, input logic [1:0] tu);
        raddr[p*AW +: AW] = ra;
        tuse[p*2 +: 2]    = tu;
    endtask

    initial begin
        rf_rdata   = {RF1, RF0};
        stage_data = {SD_W, SD_M, SD_E};
        idle();
        reset = 1'b1;

        // Reset ignores a concurrent issue; outputs stay idle during reset.
        issue(5'd4, 2'd3);
        port(0, 5'd4, 2'd0);
        port(1, 5'd4, 2'd0);
        tick();
        tick();
        settle();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_sel", {26'd0, fwd_sel}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        reset = 1'b0;
        idle();
        port(0, 5'd4, 2'd0);
        settle();
        chk("rst_tbl_empty_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("rst_tbl_empty_data0", fwd_data[31:0], RF0);

        // A ready producer walks E -> M -> W and then leaves the table.
        issue(5'd8, 2'd0);
        tick();
        idle();
        port(0, 5'd8, 2'd1);
        port(1, 5'd8, 2'd0);
        settle();
        chk("e_sel0", {29'd0, fwd_sel[2:0]}, 32'd1);
        chk("e_data0", fwd_data[31:0], SD_E);
        chk("e_sel1", {29'd0, fwd_sel[5:3]}, 32'd1);
        chk("e_data1", fwd_data[63:32], SD_E);
        chk("e_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("m_sel0", {29'd0, fwd_sel[2:0]}, 32'd2);
        chk("m_data0", fwd_data[31:0], SD_M);
        tick();
        chk("w_sel0", {29'd0, fwd_sel[2:0]}, 32'd3);
        chk("w_data0", fwd_data[31:0], SD_W);
        tick();
        chk("gone_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("gone_data0", fwd_data[31:0], RF0);

        // Load-use: two stall cycles, and a consumer held in decode is not issued meanwhile.
        issue(5'd9, 2'd2);
        tick();
        idle();
        issue(5'd12, 2'd0);
        port(0, 5'd9, 2'd0);
        settle();
        chk("lu_stall_c1", {31'd0, stall}, 32'd1);
        chk("lu_sel_c1", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("lu_data_c1", fwd_data[31:0], RF0);
        tick();
        port(1, 5'd12, 2'd0);
        settle();
        chk("lu_stall_c2", {31'd0, stall}, 32'd1);
        chk("lu_blocked_sel1", {29'd0, fwd_sel[5:3]}, 32'd0);
        tick();
        chk("lu_stall_c3", {31'd0, stall}, 32'd0);
        chk("lu_sel_c3", {29'd0, fwd_sel[2:0]}, 32'd3);
        chk("lu_data_c3", fwd_data[31:0], SD_W);
        chk("lu_cnt", stall_cnt, 32'd2);
        tick();
        idle();
        port(1, 5'd12, 2'd0);
        settle();
        chk("lu_released_sel1", {29'd0, fwd_sel[5:3]}, 32'd1);
        chk("lu_cnt_hold", stall_cnt, 32'd2);
        drain();

        // Two ready producers of r5: the youngest (E) wins.
        issue(5'd5, 2'd0);
        tick();
        issue(5'd5, 2'd0);
        tick();
        idle();
        port(1, 5'd5, 2'd0);
        settle();
        chk("young_sel1", {29'd0, fwd_sel[5:3]}, 32'd1);
        chk("young_data1", fwd_data[63:32], SD_E);
        drain();

        // Youngest r6 not ready hides the older ready r6; tnew == tuse does not stall.
        issue(5'd6, 2'd0);
        tick();
        issue(5'd6, 2'd3);
        tick();
        idle();
        port(0, 5'd6, 2'd3);
        settle();
        chk("hide_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("hide_data0", fwd_data[31:0], RF0);
        chk("eq_tuse_stall", {31'd0, stall}, 32'd0);
        port(0, 5'd6, 2'd2);
        settle();
        chk("gt_tuse_stall", {31'd0, stall}, 32'd1);
        idle();
        drain();

        // Writes to r0 and writes with wen=0 are never tracked.
        issue(5'd0, 2'd2);
        tick();
        idle();
        issue_valid = 1'b1;
        issue_waddr = 5'd10;
        issue_tnew  = 2'd2;
        port(0, 5'd0, 2'd0);
        settle();
        chk("r0_stall", {31'd0, stall}, 32'd0);
        chk("r0_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("r0_data0", fwd_data[31:0], RF0);
        tick();
        idle();
        port(0, 5'd10, 2'd0);
        settle();
        chk("nowen_stall", {31'd0, stall}, 32'd0);
        chk("nowen_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        drain();

        // A flushed issue never enters the table.
        issue(5'd7, 2'd0);
        flush = 1'b1;
        tick();
        idle();
        port(0, 5'd7, 2'd0);
        settle();
        chk("flush_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        drain();

        // Reset taken while stalled: no stall and a zero count next cycle.
        issue(5'd11, 2'd3);
        tick();
        idle();
        port(0, 5'd11, 2'd0);
        settle();
        chk("rstmid_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_cnt", stall_cnt, 32'd0);
        reset = 1'b0;
        drain();

        // Counter saturation, then reset clears the counter and the table.
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        settle();
        chk("sat_preload", stall_cnt, 32'hFFFF_FFFE);
        issue(5'd13, 2'd3);
        tick();
        idle();
        port(0, 5'd13, 2'd0);
        settle();
        chk("sat_stall_c1", {31'd0, stall}, 32'd1);
        tick();
        chk("sat_cnt_c2", stall_cnt, 32'hFFFF_FFFF);
        chk("sat_stall_c2", {31'd0, stall}, 32'd1);
        tick();
        chk("sat_stall_c3", {31'd0, stall}, 32'd1);
        tick();
        chk("sat_stall_c4", {31'd0, stall}, 32'd0);
        chk("sat_cnt_hold", stall_cnt, 32'hFFFF_FFFF);
        issue(5'd14, 2'd0);
        tick();
        idle();
        port(0, 5'd14, 2'd0);
        settle();
        chk("sat_pre_rst_sel0", {29'd0, fwd_sel[2:0]}, 32'd1);
        reset = 1'b1;
        tick();
        chk("sat_rst_cnt", stall_cnt, 32'd0);
        chk("sat_rst_sel0", {29'd0, fwd_sel[2:0]}, 32'd0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
